// File: rtl/seq_divider_16bit.sv
// 16/8 unsigned restoring divider: one quotient bit per cycle over eight CALC cycles,
// with early exit to DONE for a zero divisor or a quotient wider than 8 bits.
module seq_divider_16bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic [7:0]  quotient,
  output logic [7:0]  remainder,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic        overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  logic [8:0]  rem_r;
  logic [7:0]  q_r;
  logic [7:0]  dsr_r;
  logic [2:0]  cnt_r;

  logic [8:0]  shifted_s;
  logic [8:0]  trial_s;
  logic        trial_ok_s;
  logic [8:0]  rem_next_s;
  logic [7:0]  q_next_s;

  // One restoring step: shift the next dividend bit in, subtract the divisor when it fits.
  always_comb begin
    shifted_s  = {rem_r[7:0], q_r[7]};
    trial_s    = shifted_s - {1'b0, dsr_r};
    trial_ok_s = ({rem_r, q_r[7]} >= {2'b00, dsr_r});
    rem_next_s = trial_ok_s ? trial_s : shifted_s;
    q_next_s   = {q_r[6:0], trial_ok_s};
  end

  // Control FSM, datapath registers and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      rem_r       <= 9'd0;
      q_r         <= 8'd0;
      dsr_r       <= 8'd0;
      cnt_r       <= 3'd0;
      quotient    <= 8'd0;
      remainder   <= 8'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy  <= 1'b1;
            dsr_r <= divisor;
            // Error cases bypass CALC; both flags are rewritten so stale ones clear.
            if (divisor == 8'd0) begin
              state_r     <= DONE;
              done        <= 1'b1;
              quotient    <= 8'hFF;
              remainder   <= dividend[7:0];
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
            end else if (dividend[15:8] >= divisor) begin
              state_r     <= DONE;
              done        <= 1'b1;
              quotient    <= 8'hFF;
              remainder   <= 8'h00;
              div_by_zero <= 1'b0;
              overflow    <= 1'b1;
            end else begin
              state_r <= CALC;
              rem_r   <= {1'b0, dividend[15:8]};
              q_r     <= dividend[7:0];
              cnt_r   <= 3'd0;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        CALC: begin
          rem_r <= rem_next_s;
          q_r   <= q_next_s;
          cnt_r <= cnt_r + 3'd1;
          if (cnt_r == 3'd7) begin
            state_r     <= DONE;
            done        <= 1'b1;
            quotient    <= q_next_s;
            remainder   <= rem_next_s[7:0];
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end else begin
            state_r <= CALC;
          end
        end
        DONE: begin
          state_r <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_16bit.sv
// Self-checking bench for seq_divider_16bit: cycle-level behavioural model plus directed
// literal cases, followed by a randomized regression of 10k operand pairs.
module tb_seq_divider_16bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dividend = 16'd0;
  logic [7:0]  divisor = 8'd0;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic        overflow;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  seq_divider_16bit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Inputs as seen by the DUT at each rising edge
  logic        s_start = 1'b0;
  logic [15:0] s_dd = 16'd0;
  logic [7:0]  s_ds = 8'd0;
  always @(posedge clk) begin
    s_start <= start;
    s_dd    <= dividend;
    s_ds    <= divisor;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result by plain arithmetic: {div_by_zero, overflow, quotient, remainder}
  function automatic logic [17:0] ref_div(input logic [15:0] dd, input logic [7:0] ds);
    int quo;
    if (ds == 8'd0) return {1'b1, 1'b0, 8'hFF, dd[7:0]};
    quo = int'(dd) / int'(ds);
    if (quo > 255) return {2'b01, 8'hFF, 8'h00};
    return {2'b00, 8'(quo), 8'(int'(dd) % int'(ds))};
  endfunction

  // Behavioural model: busy window, done pulse and held outputs; compared every cycle.
  logic        m_busy = 1'b0, m_done = 1'b0;
  int          m_left = 0;
  logic [17:0] m_out = 18'd0;
  logic [17:0] m_pend = 18'd0;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_left = 0; m_out = 18'd0;
    end else if (m_done) begin
      m_done = 1'b0; m_busy = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1; m_out = m_pend;
      end
    end else if (s_start) begin
      m_busy = 1'b1;
      m_pend = ref_div(s_dd, s_ds);
      if (m_pend[17] | m_pend[16]) begin
        m_done = 1'b1; m_out = m_pend;
      end else begin
        m_left = 8;
      end
    end
    check("cycle", {12'd0, busy, done, div_by_zero, overflow, quotient, remainder},
          {12'd0, m_busy, m_done, m_out[17], m_out[16], m_out[15:8], m_out[7:0]});
    if (done === 1'b1) done_cnt++;
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  // Issue one operation, scramble operands after acceptance, wait for done.
  // lat counts cycles from the one start is presented in to the one done is high in.
  task automatic run_op(input logic [15:0] dd, input logic [7:0] ds, input bit junk, output int lat);
    start = 1'b1; dividend = dd; divisor = ds;
    tick();
    start = 1'b0; dividend = 16'($urandom); divisor = 8'($urandom);
    lat = 1;
    while (done !== 1'b1 && lat < 16) begin
      tick();
      lat++;
    end
    if (done !== 1'b1) begin
      total++; bad++;
      $display("FAIL timeout: no done for %0h/%0h", dd, ds);
    end
    lat = lat + 1;
    // A start during the DONE cycle must be dropped
    if (junk) begin
      start = 1'b1; dividend = 16'($urandom); divisor = 8'($urandom);
    end
    tick();
    start = 1'b0;
  endtask

  function automatic logic [31:0] outs();
    return {14'd0, div_by_zero, overflow, quotient, remainder};
  endfunction

  initial begin
    int lat, dc, sel;
    logic [15:0] dd;
    logic [7:0] ds;
    logic [17:0] e;

    repeat (2) tick();
    check("reset_state", {22'd0, busy, done, outs()}, 32'd0);
    rst_n = 1'b1;
    tick();

    run_op(16'd100, 8'd7, 1'b1, lat);
    check("lat_100_7", lat, 10);
    check("res_100_7", outs(), {14'd0, 2'b00, 8'd14, 8'd2});
    check("idle_after_done_start", {31'd0, busy}, 32'd0);

    run_op(16'hFEFF, 8'hFF, 1'b0, lat);
    check("res_feff_ff", outs(), {14'd0, 2'b00, 8'hFF, 8'hFE});
    run_op(16'h00FF, 8'h01, 1'b0, lat);
    check("res_00ff_01", outs(), {14'd0, 2'b00, 8'hFF, 8'h00});

    run_op(16'h1234, 8'h12, 1'b0, lat);
    check("lat_ovf", lat, 2);
    check("res_ovf", outs(), {14'd0, 2'b01, 8'hFF, 8'h00});
    run_op(16'h00AB, 8'h00, 1'b0, lat);
    check("lat_dbz", lat, 2);
    check("res_dbz", outs(), {14'd0, 2'b10, 8'hFF, 8'hAB});

    // Second start during CALC is ignored
    dc = done_cnt;
    start = 1'b1; dividend = 16'd500; divisor = 8'd3;
    tick();
    start = 1'b0;
    repeat (3) tick();
    start = 1'b1; dividend = 16'd40000; divisor = 8'd200;
    tick();
    start = 1'b0;
    repeat (12) tick();
    check("res_ignore", outs(), {14'd0, 2'b00, 8'd166, 8'd2});
    check("one_done", done_cnt - dc, 1);

    // Reset during CALC: immediate clear, no done for the aborted op
    start = 1'b1; dividend = 16'd1000; divisor = 8'd9;
    tick();
    start = 1'b0;
    repeat (4) tick();
    dc = done_cnt;
    rst_n = 1'b0;
    #1;
    check("async_reset", {22'd0, busy, done, outs()}, 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (12) tick();
    check("no_done_abort", done_cnt - dc, 0);
    run_op(16'd1000, 8'd9, 1'b0, lat);
    check("res_1000_9", outs(), {14'd0, 2'b00, 8'd111, 8'd1});

    for (int i = 0; i < 10000; i++) begin
      sel = int'($urandom_range(0, 9));
      ds = 8'($urandom_range(1, 255));
      if (sel <= 4) begin
        dd = {8'($urandom_range(0, int'(ds) - 1)), 8'($urandom)};
      end else if (sel <= 6) begin
        dd = 16'($urandom); ds = 8'($urandom);
      end else if (sel <= 8) begin
        dd = 16'($urandom); ds = 8'd0;
      end else begin
        dd = {ds - 8'($urandom_range(0, 1)), 8'($urandom)};
      end
      run_op(dd, ds, ($urandom_range(0, 7) == 0), lat);
      e = ref_div(dd, ds);
      check("lat_rand", lat, (e[17] | e[16]) ? 32'd2 : 32'd10);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_divider_16bit.md
SEQ_DIVIDER_16BIT -- requirements
Module: seq_divider_16bit

Interface
REQ-001 Parameters: none; the 16/8 operand widths SHALL be fixed.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin a division; sampled on the rising edge.
REQ-005 dividend  input  16  unsigned dividend; sampled only when start is accepted.
REQ-006 divisor  input  8  unsigned divisor; sampled only when start is accepted.
REQ-007 quotient  output  8  registered unsigned quotient.
REQ-008 remainder  output  8  registered unsigned remainder.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 done  output  1  single-cycle pulse marking a valid result.
REQ-011 div_by_zero  output  1  error flag for divisor == 0; valid with done.
REQ-012 overflow  output  1  error flag for a quotient that does not fit in 8 bits; valid with done.

Function
REQ-013 The block SHALL be the inverse of the team's 8x8 array multiplier: quotient*divisor + remainder == dividend, with remainder < divisor, for every non-error case.
REQ-014 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-015 In IDLE with start=1, the block SHALL latch dividend and divisor; busy SHALL rise in the next cycle.
REQ-016 start SHALL be ignored in CALC and DONE; no queuing.
REQ-017 On start with divisor == 0, the FSM SHALL go IDLE -> DONE.
- div_by_zero=1, quotient=8'hFF, remainder=dividend[7:0].
REQ-018 On start with divisor != 0 and dividend[15:8] >= divisor, the FSM SHALL go IDLE -> DONE.
- overflow=1, quotient=8'hFF, remainder=8'h00.
REQ-019 Otherwise the FSM SHALL go IDLE -> CALC.
- Load 9-bit partial remainder R = {1'b0, dividend[15:8]} and shift register Q = dividend[7:0].
- Load 3-bit iteration counter = 0.
REQ-020 Each CALC cycle SHALL perform one restoring step:
- T = {R[7:0], Q[7]} - {1'b0, divisor}, computed 9 bits wide.
- If T >= 0: R = T and Q = {Q[6:0], 1'b1}; else R = {R[7:0], Q[7]} and Q = {Q[6:0], 1'b0}.
REQ-021 CALC SHALL last exactly 8 cycles; on counter == 7 the FSM SHALL go to DONE.
REQ-022 Quotient, remainder and flags SHALL be written only on entry to DONE (quotient = Q, remainder = R[7:0]).
REQ-023 The outputs SHALL then hold until the next accepted start.
REQ-024 Flags not set by the current operation SHALL be cleared when the outputs are written.
REQ-025 done SHALL be high for exactly one cycle, while in DONE; DONE SHALL always go to IDLE next.
REQ-026 Latency, start edge to done high:
- 10 cycles for a normal division (1 accept + 8 CALC + DONE).
- 2 cycles for error cases.
REQ-027 A start in the cycle where the FSM returns from DONE to IDLE SHALL be ignored; start is accepted only while already in IDLE.
REQ-028 Changes on dividend or divisor after acceptance SHALL NOT affect the result in progress.

Reset
REQ-029 When rst_n=0, the block SHALL immediately, without waiting for clk, force:
- state=IDLE, counter=0, R=0, Q=0
- quotient=0, remainder=0, busy=0, done=0, div_by_zero=0, overflow=0
REQ-030 Reset asserted mid-CALC SHALL abort the operation; no done SHALL be produced for the aborted operation.
REQ-031 After rst_n rises, the first start SHALL be accepted on the first rising edge.

Verification
REQ-032 Divide 16'd100 by 8'd7 -> done 10 cycles after start; quotient=14, remainder=2, no flags set.
REQ-033 Divide 16'hFEFF by 8'hFF -> quotient=8'hFF, remainder=8'hFE, overflow=0; also 16'h00FF by 8'h01 -> quotient=8'hFF, remainder=0.
REQ-034 Divide 16'h1234 by 8'h12 -> done after 2 cycles, overflow=1, quotient=8'hFF, remainder=0; then divisor=0 with dividend 16'h00AB -> div_by_zero=1, quotient=8'hFF, remainder=8'hAB, overflow=0.
REQ-035 Pulse start again during CALC with different operands -> ignored; the first result is unchanged and exactly one done pulse occurs.
REQ-036 Drive rst_n low at CALC cycle 4 -> all outputs 0 asynchronously, no done; then 16'd1000 by 8'd9 -> quotient=111, remainder=1.
REQ-037 Random regression of at least 10k operand pairs SHALL be checked against a reference model implementing REQ-013, REQ-017 and REQ-018.
